servo_pwm_sched: RTL and testbench

Multi-channel hobby-servo pulse scheduler for the Servo subsystem. It generates one free-running 1 µs tick enable internally from clk, with no derived clocks. It runs a fixed 20 ms frame and drives each servo channel in its own time slot with a 1.000–2.020 ms pulse set by an 8-bit position. Position writes from the host-side logic are double-buffered and applied only at frame boundaries, so a pulse is never glitched.

---
 rtl/servo_pwm_sched.sv | 169 ++++++++++++++++
 tb/tb_servo_pwm_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_sched.sv
// rtl/servo_pwm_sched.sv - multi-channel hobby-servo pulse scheduler with frame-boundary position latch
module servo_pwm_sched #(
    parameter int CLK_DIV   = 100,
    parameter int N_CH      = 4,
    parameter int FRAME_US  = 20000,
    parameter int SLOT_US   = 2500,
    parameter int PULSE_MIN = 1000,
    parameter int STEP      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_en,
    input  logic [2:0]      wr_ch,
    input  logic [7:0]      wr_pos,
    output logic [N_CH-1:0] servo_out,
    output logic            frame_start,
    output logic [2:0]      cur_ch,
    output logic            busy
);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, PULSE, SLOT_REST, FRAME_GAP} state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [14:0]      us_cnt_q, us_cnt_d;
    logic [14:0]      slot_base_q, slot_base_d;
    logic [2:0]       ch_q, ch_d;
    logic [N_CH-1:0]  servo_out_q, servo_out_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic [7:0]       active_q [N_CH];
    logic [7:0]       active_d [N_CH];
    logic [7:0]       pending_q [N_CH];
    logic [7:0]       pending_d [N_CH];
    logic [7:0]       cur_pos;
    logic [11:0]      pulse_ticks;
    logic [14:0]      pulse_last;
    logic [14:0]      slot_rel;
    logic             frame_done;
    logic             start_frame;

    always_comb begin
        cur_pos = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 3'(i)) cur_pos = active_q[i];
        end
        pulse_ticks = 12'(PULSE_MIN) + 12'(cur_pos) * 12'(STEP);
        pulse_last  = {3'b000, pulse_ticks - 12'd1};
        // Slot-relative time; slot_base_q holds the frame time at which the current slot began.
        slot_rel    = us_cnt_q - slot_base_q;
    end

    always_comb begin
        tick          = (div_q == DIV_W'(CLK_DIV - 1));
        div_d         = tick ? '0 : div_q + 1'b1;
        state_d       = state_q;
        us_cnt_d      = us_cnt_q;
        slot_base_d   = slot_base_q;
        ch_d          = ch_q;
        servo_out_d   = servo_out_q;
        frame_start_d = 1'b0;
        busy_d        = busy_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_done    = 1'b0;
        start_frame   = 1'b0;

        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && wr_ch == 3'(i)) pending_d[i] = wr_pos;
        end

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (en) start_frame = 1'b1;
                end
                PULSE: begin
                    us_cnt_d = us_cnt_q + 15'd1;
                    if (slot_rel == pulse_last) begin
                        servo_out_d = '0;
                        state_d     = SLOT_REST;
                    end
                end
                SLOT_REST: begin
                    us_cnt_d = us_cnt_q + 15'd1;
                    if (slot_rel == 15'(SLOT_US - 1)) begin
                        if (ch_q != 3'(N_CH - 1)) begin
                            ch_d        = ch_q + 3'd1;
                            slot_base_d = us_cnt_q + 15'd1;
                            servo_out_d = N_CH'(1) << ch_d;
                            state_d     = PULSE;
                        // Slots may fill the whole frame, leaving no gap to sit in.
                        end else if (us_cnt_q == 15'(FRAME_US - 1)) begin
                            frame_done = 1'b1;
                        end else begin
                            state_d = FRAME_GAP;
                        end
                    end
                end
                FRAME_GAP: begin
                    us_cnt_d = us_cnt_q + 15'd1;
                    if (us_cnt_q == 15'(FRAME_US - 1)) frame_done = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (frame_done) begin
            if (en) begin
                start_frame = 1'b1;
            end else begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                ch_d        = '0;
                servo_out_d = '0;
                us_cnt_d    = '0;
                slot_base_d = '0;
            end
        end

        if (start_frame) begin
            active_d      = pending_q;
            frame_start_d = 1'b1;
            ch_d          = '0;
            us_cnt_d      = '0;
            slot_base_d   = '0;
            servo_out_d   = N_CH'(1);
            busy_d        = 1'b1;
            state_d       = PULSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            state_q       <= IDLE;
            us_cnt_q      <= '0;
            slot_base_q   <= '0;
            ch_q          <= '0;
            servo_out_q   <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                active_q[i]  <= '0;
                pending_q[i] <= '0;
            end
        end else begin
            div_q         <= div_d;
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            slot_base_q   <= slot_base_d;
            ch_q          <= ch_d;
            servo_out_q   <= servo_out_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
        end
    end

    assign servo_out   = servo_out_q;
    assign frame_start = frame_start_q;
    assign cur_ch      = ch_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_sched.sv
// tb/tb_servo_pwm_sched.sv - directed self-checking bench for servo_pwm_sched
module tb_servo_pwm_sched;
    logic       clk;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_pos;
    logic [3:0] servo_out;
    logic       frame_start;
    logic [2:0] cur_ch;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int now = 0;
    int t0 = 0;
    int t1 = 0;

    int cyc = 0;
    int rise_c [4];
    int width_c [4];
    int fs_last = 0;
    int fs_prev = 0;
    int fs_count = 0;
    int multi_hot = 0;
    logic [3:0] prev_out = 4'b0000;

    servo_pwm_sched #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .servo_out(servo_out), .frame_start(frame_start), .cur_ch(cur_ch), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < 4; c++) begin
            if (servo_out[c] && !prev_out[c]) rise_c[c] = cyc;
            if (!servo_out[c] && prev_out[c]) width_c[c] = cyc - rise_c[c];
        end
        if (frame_start) begin
            fs_prev = fs_last;
            fs_last = cyc;
            fs_count = fs_count + 1;
        end
        if ($countones(servo_out) > 1) multi_hot = multi_hot + 1;
        prev_out = servo_out;
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            now = now + 1;
        end
    endtask

    task automatic goto(input int t);
        if (t > now) step(t - now);
    endtask

    task automatic write_pos(input logic [2:0] ch, input logic [7:0] pos);
        wr_en = 1'b1; wr_ch = ch; wr_pos = pos;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = 3'd0; wr_pos = 8'd0;
        step(3);
        checks++; if (servo_out !== 4'b0000) begin errors++; $display("FAIL reset_servo_out: got %b expected 0000", servo_out); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (cur_ch !== 3'd0) begin errors++; $display("FAIL reset_cur_ch: got %0d expected 0", cur_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_pulse;
        bit seen;
        write_pos(3'd0, 8'd200);
        en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(1);
            if (frame_start) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL first_frame_start: got none expected within 10 cycles"); end
        step(50);
        checks++; if (servo_out !== 4'b0001) begin errors++; $display("FAIL ch0_pulse_before_rst: got %b expected 0001", servo_out); end
        rst = 1'b1;
        step(1);
        checks++; if (servo_out !== 4'b0000) begin errors++; $display("FAIL rst_mid_pulse_out: got %b expected 0000", servo_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse_busy: got %b expected 0", busy); end
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_latch_write;
        step(1);
        wr_en = 1'b1; wr_ch = 3'd3; wr_pos = 8'd10;
        step(1);
        wr_en = 1'b0;
        t0 = now;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL latch_frame_start: got %b expected 1", frame_start); end
        checks++; if (servo_out !== 4'b0001) begin errors++; $display("FAIL latch_ch0_rise: got %b expected 0001", servo_out); end
    endtask

    task automatic test_frame_a;
        goto(t0 + 1000);
        write_pos(3'd1, 8'd255);
        write_pos(3'd2, 8'd0);
        write_pos(3'd5, 8'd50);
        write_pos(3'd6, 8'd77);
        goto(t0 + 17100);
        for (int c = 0; c < 4; c++) begin
            checks++; if (width_c[c] !== 2000) begin errors++; $display("FAIL frameA_width_ch%0d: got %0d expected 2000 cycles", c, width_c[c]); end
        end
        for (int c = 0; c < 3; c++) begin
            checks++; if (rise_c[c+1] - rise_c[c] !== 5000) begin errors++; $display("FAIL frameA_spacing_ch%0d: got %0d expected 5000 cycles", c + 1, rise_c[c+1] - rise_c[c]); end
        end
        goto(t0 + 39999);
        checks++; if (frame_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL frameA_end_early: got fs=%b busy=%b expected fs=0 busy=1", frame_start, busy); end
        step(1);
        t1 = now;
        checks++; if (frame_start !== 1'b1 || servo_out !== 4'b0001) begin errors++; $display("FAIL frameB_start: got fs=%b out=%b expected fs=1 out=0001", frame_start, servo_out); end
        step(1);
        checks++; if (fs_last - fs_prev !== 40000) begin errors++; $display("FAIL frame_period: got %0d expected 40000 cycles", fs_last - fs_prev); end
    endtask

    task automatic test_frame_b_disable;
        int exp_w [4];
        int n;
        exp_w = '{2000, 4040, 2000, 2080};
        goto(t1 + 5500);
        checks++; if (servo_out !== 4'b0010 || cur_ch !== 3'd1) begin errors++; $display("FAIL frameB_ch1_pulse: got out=%b ch=%0d expected out=0010 ch=1", servo_out, cur_ch); end
        en = 1'b0;
        goto(t1 + 17200);
        for (int c = 0; c < 4; c++) begin
            checks++; if (width_c[c] !== exp_w[c]) begin errors++; $display("FAIL frameB_width_ch%0d: got %0d expected %0d cycles", c, width_c[c], exp_w[c]); end
        end
        goto(t1 + 30000);
        checks++; if (cur_ch !== 3'd3 || servo_out !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL frame_gap: got ch=%0d out=%b busy=%b expected ch=3 out=0000 busy=1", cur_ch, servo_out, busy); end
        goto(t1 + 39999);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_end: got %b expected 1", busy); end
        step(1);
        checks++; if (busy !== 1'b0 || cur_ch !== 3'd0 || frame_start !== 1'b0) begin errors++; $display("FAIL frame_end_idle: got busy=%b ch=%0d fs=%b expected 0 0 0", busy, cur_ch, frame_start); end
        n = fs_count;
        goto(t1 + 40100);
        checks++; if (fs_count !== n || busy !== 1'b0) begin errors++; $display("FAIL idle_no_frame: got starts=%0d busy=%b expected starts=%0d busy=0", fs_count, busy, n); end
    endtask

    task automatic test_restart;
        en = 1'b1;
        step(1);
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL restart_early: got %b expected 0", frame_start); end
        step(1);
        checks++; if (frame_start !== 1'b1 || servo_out !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL restart_frame: got fs=%b out=%b busy=%b expected 1 0001 1", frame_start, servo_out, busy); end
        step(10);
    endtask

    task automatic test_onehot;
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL onehot: got %0d multi-hot cycles expected 0", multi_hot); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_pulse;
        test_latch_write;
        test_frame_a;
        test_frame_b_disable;
        test_restart;
        test_onehot;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
